ccg_resp_compactor: RTL and testbench

//  Output-response compactor placed directly downstream of a generated combinational

---
 rtl/ccg_resp_compactor_if.sv | 37 +++
 rtl/ccg_resp_compactor.sv | 119 +++++++++++
 tb/tb_ccg_resp_compactor.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ccg_resp_compactor_if.sv
// ============================================================================
// Module   : ccg_resp_compactor_if
// Brief    : Control, response and result bundle for the response compactor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ccg_resp_compactor_if #(
    parameter int OUT_W = 18,
    parameter int SIG_W = 32,
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_patterns;
    logic             resp_valid;
    logic [OUT_W-1:0] resp_data;
    logic             resp_ready;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [ACC_W-1:0] ones_count;
    logic [CNT_W-1:0] beat_count;

    modport master (
        output start, abort, num_patterns, resp_valid, resp_data,
        input  resp_ready, busy, done, signature, ones_count, beat_count
    );

    modport slave (
        input  start, abort, num_patterns, resp_valid, resp_data,
        output resp_ready, busy, done, signature, ones_count, beat_count
    );
endinterface

`default_nettype wire

// File: rtl/ccg_resp_compactor.sv
// ============================================================================
// Module   : ccg_resp_compactor
// Brief    : MISR + saturating ones-count compactor for core response vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccg_resp_compactor #(
    parameter int               OUT_W = 18,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF,
    parameter int               CNT_W = 16,
    parameter int               ACC_W = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    ccg_resp_compactor_if.slave         bus_io
);

    localparam int PC_W = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [SIG_W-1:0] sig_q,    sig_d;
    logic [ACC_W-1:0] ones_q,   ones_d;
    logic [CNT_W-1:0] beat_q,   beat_d;
    logic [CNT_W-1:0] target_q, target_d;

    logic [SIG_W-1:0] w_misr;
    logic [PC_W-1:0]  w_pop;
    logic [ACC_W:0]   w_ones_sum;
    logic [ACC_W-1:0] w_ones_sat;
    logic [CNT_W-1:0] w_beat_inc;

    function automatic logic [PC_W-1:0] popcnt(input logic [OUT_W-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < OUT_W; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    assign w_misr     = {sig_q[SIG_W-2:0], 1'b0}
                      ^ (sig_q[SIG_W-1] ? POLY : '0)
                      ^ SIG_W'(bus_io.resp_data);
    assign w_pop      = popcnt(bus_io.resp_data);
    // One extra bit catches the overflow so the count sticks at all-ones
    assign w_ones_sum = {1'b0, ones_q} + (ACC_W+1)'(w_pop);
    assign w_ones_sat = w_ones_sum[ACC_W] ? '1 : w_ones_sum[ACC_W-1:0];
    assign w_beat_inc = beat_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        ones_d   = ones_q;
        beat_d   = beat_q;
        target_d = target_q;
        if (bus_io.abort) begin
            // Results are kept for inspection; the next start re-seeds them
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus_io.start) begin
                        sig_d    = SEED;
                        ones_d   = '0;
                        beat_d   = '0;
                        target_d = bus_io.num_patterns;
                        state_d  = (bus_io.num_patterns == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus_io.resp_valid) begin
                        sig_d  = w_misr;
                        ones_d = w_ones_sat;
                        beat_d = w_beat_inc;
                        if (w_beat_inc == target_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sig_q    <= SEED;
            ones_q   <= '0;
            beat_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            ones_q   <= ones_d;
            beat_q   <= beat_d;
            target_q <= target_d;
        end
    end

    assign bus_io.resp_ready = (state_q == ST_RUN);
    assign bus_io.busy       = (state_q == ST_RUN);
    assign bus_io.done       = (state_q == ST_DONE);
    assign bus_io.signature  = sig_q;
    assign bus_io.ones_count = ones_q;
    assign bus_io.beat_count = beat_q;

endmodule

`default_nettype wire

// File: tb/tb_ccg_resp_compactor.sv
// ============================================================================
// Module   : tb_ccg_resp_compactor
// Brief    : Scoreboard bench for the response compactor sessions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccg_resp_compactor;

    localparam int          OUT_W = 18;
    localparam int          SIG_W = 32;
    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [31:0] SEED  = 32'hFFFFFFFF;
    localparam int          CNT_W = 16;
    localparam int          ACC_W = 24;

    typedef struct packed {
        logic [SIG_W-1:0] sig;
        logic [ACC_W-1:0] ones;
        logic [CNT_W-1:0] beats;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ccg_resp_compactor_if #(.OUT_W(OUT_W), .SIG_W(SIG_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

    ccg_resp_compactor #(
        .OUT_W(OUT_W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED), .CNT_W(CNT_W), .ACC_W(ACC_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [SIG_W-1:0] m_sig;
    logic [ACC_W-1:0] m_ones;
    logic [CNT_W-1:0] m_beats;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input logic [OUT_W-1:0] d);
        logic [ACC_W:0] s;
        m_sig = {m_sig[SIG_W-2:0], 1'b0} ^ (m_sig[SIG_W-1] ? POLY : 32'h0) ^ SIG_W'(d);
        s     = {1'b0, m_ones} + (ACC_W+1)'($countones(d));
        m_ones  = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
        m_beats = m_beats + 1'b1;
    endtask

    task automatic start_session(input logic [CNT_W-1:0] n);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.num_patterns = n;
        @(negedge clk);
        bus.start = 1'b0;
        m_sig     = SEED;
        m_ones    = '0;
        m_beats   = '0;
    endtask

    task automatic drive_beat(input logic [OUT_W-1:0] d);
        check("ready_before_beat", bus.resp_ready, 1);
        bus.resp_valid = 1'b1;
        bus.resp_data  = d;
        model_beat(d);
        @(negedge clk);
        bus.resp_valid = 1'b0;
    endtask

    task automatic bubble();
        bus.resp_valid = 1'b0;
        bus.resp_data  = OUT_W'($urandom);
        @(negedge clk);
    endtask

    task automatic push_exp();
        sb_q.push_back('{sig: m_sig, ones: m_ones, beats: m_beats});
    endtask

    task automatic wait_and_compare(input string tag);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_sig"},   bus.signature,  e.sig);
            check({tag, "_ones"},  bus.ones_count, e.ones);
            check({tag, "_beats"}, bus.beat_count, e.beats);
        end
        check({tag, "_ready_low"}, bus.resp_ready, 0);
        check({tag, "_busy_low"},  bus.busy, 0);
    endtask

    initial begin
        logic [OUT_W-1:0] d3 [3];
        logic [SIG_W-1:0] held;

        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.num_patterns = '0;
        bus.resp_valid = 1'b0; bus.resp_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sig",   bus.signature,  SEED);
        check("rst_ones",  bus.ones_count, 0);
        check("rst_beats", bus.beat_count, 0);
        check("rst_ready", bus.resp_ready, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);

        // Single zero beat: done on the very next sample
        start_session(1);
        check("t1_busy", bus.busy, 1);
        drive_beat(18'h00000);
        check("t1_done_next", bus.done, 1);
        check("t1_sig_const", bus.signature, 32'hFB3EE249);
        push_exp();
        wait_and_compare("t1");
        held = bus.signature;
        bus.resp_valid = 1'b1; bus.resp_data = 18'h3FFFF;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        check("t1_done_hold", bus.done, 1);
        check("t1_sig_hold", bus.signature, held);

        start_session(1);
        drive_beat(18'h00001);
        check("t2a_sig_const", bus.signature, 32'hFB3EE248);
        push_exp();
        wait_and_compare("t2a");

        start_session(1);
        drive_beat(18'h3FFFF);
        check("t2b_ones_const", bus.ones_count, 18);
        push_exp();
        wait_and_compare("t2b");

        // Zero-length session
        start_session(0);
        check("t3_done", bus.done, 1);
        check("t3_ready", bus.resp_ready, 0);
        check("t3_sig", bus.signature, SEED);
        push_exp();
        wait_and_compare("t3");

        // Bubbles in between, plus an ignored start while running
        for (int i = 0; i < 3; i++) d3[i] = OUT_W'($urandom);
        start_session(3);
        drive_beat(d3[0]);
        bubble();
        bus.start = 1'b1; bus.num_patterns = 16'd7;
        bubble();
        bus.start = 1'b0;
        check("t4_busy_mid", bus.busy, 1);
        drive_beat(d3[1]);
        bubble();
        check("t4_not_done_early", bus.done, 0);
        drive_beat(d3[2]);
        check("t4_done_next", bus.done, 1);
        push_exp();
        wait_and_compare("t4");

        // Abort partway, then abort+start together, then a fresh session
        start_session(5);
        drive_beat(OUT_W'($urandom));
        drive_beat(OUT_W'($urandom));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t5_abort_busy", bus.busy, 0);
        check("t5_abort_done", bus.done, 0);
        check("t5_abort_sig_held", bus.signature, m_sig);
        check("t5_abort_beats_held", bus.beat_count, 2);
        bus.abort = 1'b1; bus.start = 1'b1; bus.num_patterns = 16'd1;
        @(negedge clk);
        bus.abort = 1'b0; bus.start = 1'b0;
        check("t5_abort_start_busy", bus.busy, 0);
        check("t5_abort_start_done", bus.done, 0);
        start_session(1);
        check("t5_reseed_sig", bus.signature, SEED);
        check("t5_reseed_beats", bus.beat_count, 0);
        drive_beat(18'h2A5A5);
        push_exp();
        wait_and_compare("t5");

        // Asynchronous reset between clock edges
        start_session(4);
        drive_beat(18'h1F0F0);
        #3;
        rst = 1'b1;
        #1;
        check("t6_sig",   bus.signature,  SEED);
        check("t6_ones",  bus.ones_count, 0);
        check("t6_beats", bus.beat_count, 0);
        check("t6_ready", bus.resp_ready, 0);
        check("t6_busy",  bus.busy, 0);
        check("t6_done",  bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_after", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
